// File: rtl/lancer_roulement.sv
// Roll engine: spins a counter through a latched [Min,Max] range while Lancer is held, then decelerates over NB_PAS steps and latches the result.
// Latency: one edge to load Min_l, one step per held edge, settle takes DIV_BASE*(2^NB_PAS-1) edges after release; all outputs registered.
// Backpressure: none; Lancer is a level input sampled every edge, and results are announced by a one-cycle Valide pulse.
//
// Ports:
//   CLK, RST_N   : system clock (rising edge), asynchronous active-low reset
//   Min, Max     : face range from the decoder, sampled only on the roll-start edge
//   Lancer       : roll button (debounced, synchronous), level-sensitive
//   Affiche      : live counter value, for the spin animation
//   Valeur       : last settled result, held until the next settle
//   Valide       : one-cycle pulse on the edge that updates Valeur
//   Occupe       : high while spinning or decelerating
module lancer_roulement #(
  parameter int NB_PAS   = 8,
  parameter int DIV_BASE = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] Min,
  input  logic [6:0] Max,
  input  logic       Lancer,
  output logic [6:0] Affiche,
  output logic [6:0] Valeur,
  output logic       Valide,
  output logic       Occupe
);

  localparam logic [1:0] ATTENTE = 2'd0;
  localparam logic [1:0] ROULE   = 2'd1;
  localparam logic [1:0] RALENTI = 2'd2;
  localparam logic [1:0] FINI    = 2'd3;

  localparam int PW = (NB_PAS < 2) ? 1 : $clog2(NB_PAS + 1);

  logic [1:0]    etat;
  logic [6:0]    cnt;
  logic [6:0]    min_l;
  logic [6:0]    max_l;
  logic [PW-1:0] pas;
  logic [15:0]   intervalle;
  logic [15:0]   tempo;

  logic [6:0]    cnt_pas;
  logic [PW-1:0] pas_suiv;
  logic          fin_tempo;

  // Wrap at the latched upper bound keeps the counter inside [min_l, max_l].
  always_comb begin
    cnt_pas   = (cnt == max_l) ? min_l : cnt + 7'd1;
    pas_suiv  = pas + {{(PW-1){1'b0}}, 1'b1};
    fin_tempo = (tempo == intervalle - 16'd1);
  end

  assign Affiche = cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      etat       <= ATTENTE;
      cnt        <= 7'd0;
      min_l      <= 7'd0;
      max_l      <= 7'd0;
      pas        <= '0;
      intervalle <= 16'd0;
      tempo      <= 16'd0;
      Valeur     <= 7'd0;
      Valide     <= 1'b0;
      Occupe     <= 1'b0;
    end else begin
      // Valide is only raised on the FINI entry edge, so it drops on the next one.
      Valide <= 1'b0;
      case (etat)
        ATTENTE, FINI: begin
          if (Lancer) begin
            etat   <= ROULE;
            Occupe <= 1'b1;
            min_l  <= Min;
            // An inverted range collapses to the single face Min.
            max_l  <= (Min > Max) ? Min : Max;
            cnt    <= Min;
          end
        end
        ROULE: begin
          if (Lancer) begin
            cnt <= cnt_pas;
          end else begin
            // Release edge: no step, the deceleration schedule starts fresh.
            etat       <= RALENTI;
            pas        <= '0;
            intervalle <= 16'(DIV_BASE);
            tempo      <= 16'd0;
          end
        end
        RALENTI: begin
          if (Lancer) begin
            // Re-press wins over any step due on this edge; spin resumes from cnt.
            etat <= ROULE;
          end else if (fin_tempo) begin
            cnt        <= cnt_pas;
            pas        <= pas_suiv;
            intervalle <= intervalle << 1;
            tempo      <= 16'd0;
            if (pas_suiv == PW'(NB_PAS)) begin
              etat   <= FINI;
              Valeur <= cnt_pas;
              Valide <= 1'b1;
              Occupe <= 1'b0;
            end
          end else begin
            tempo <= tempo + 16'd1;
          end
        end
        default: etat <= ATTENTE;
      endcase
    end
  end

endmodule

// File: tb/tb_lancer_roulement.sv
// Bench for lancer_roulement with NB_PAS=2, DIV_BASE=1 (3-edge settle).
// Stimulus pushes each expected settled value; a monitor pops on every Valide.
// No backpressure; all bounded waits report FAIL on expiry.
module tb_lancer_roulement;

  logic       CLK;
  logic       RST_N;
  logic [6:0] Min;
  logic [6:0] Max;
  logic       Lancer;
  logic [6:0] Affiche;
  logic [6:0] Valeur;
  logic       Valide;
  logic       Occupe;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];

  lancer_roulement #(.NB_PAS(2), .DIV_BASE(1)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .Min    (Min),
    .Max    (Max),
    .Lancer (Lancer),
    .Affiche(Affiche),
    .Valeur (Valeur),
    .Valide (Valide),
    .Occupe (Occupe)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_range(input string name, input int lo, input int hi);
    checks++;
    if (int'(Affiche) < lo || int'(Affiche) > hi) begin
      errors++;
      $display("FAIL %s: Affiche=%0d outside [%0d,%0d] (t=%0t)", name, Affiche, lo, hi, $time);
    end
  endtask

  // Waits for Occupe to drop, checking Affiche stays in range on the way.
  task automatic wait_idle(input string name, input int lo, input int hi, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge CLK);
      chk_range(name, lo, hi);
      if (!Occupe) done = 1'b1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: Occupe=%0d after %0d cycles, expected 0", name, Occupe, budget);
    end
  endtask

  // Full roll: press for 'hold' edges, release, wait for settle.
  // chg_at >= 0 moves Min/Max to 0/99 mid-spin to prove they are ignored.
  task automatic roll(input string name, input logic [6:0] mn, input logic [6:0] mx,
                      input int hold, input int lo, input int hi,
                      input logic [6:0] expv, input int chg_at);
    @(negedge CLK);
    Min = mn;
    Max = mx;
    Lancer = 1'b1;
    exp_q.push_back(expv);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk_range(name, lo, hi);
      if (i == chg_at) begin
        Min = 7'd0;
        Max = 7'd99;
      end
    end
    Lancer = 1'b0;
    wait_idle(name, lo, hi, 50);
  endtask

  // Scoreboard monitor: every Valide pulse must match the oldest expectation.
  initial begin
    logic prev_valide;
    logic [6:0] e;
    prev_valide = 1'b0;
    forever begin
      @(negedge CLK);
      if (Valide) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valide: Valeur=%0d with no roll pending (t=%0t)", Valeur, $time);
        end else begin
          e = exp_q.pop_front();
          chk("valeur", Valeur, e);
          chk("occupe_at_valide", Occupe, 0);
        end
        if (prev_valide) chk("valide_width", 2, 1);
      end
      prev_valide = Valide;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N  = 1'b0;
    Lancer = 1'b0;
    Min    = 7'd0;
    Max    = 7'd0;
    #12;
    chk("rst_affiche", Affiche, 0);
    chk("rst_valeur", Valeur, 0);
    chk("rst_valide", Valide, 0);
    chk("rst_occupe", Occupe, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // 1..6, hold 3 edges: 1,2,3; release holds 3; settle 4 then 5.
    @(negedge CLK);
    Min = 7'd1;
    Max = 7'd6;
    Lancer = 1'b1;
    exp_q.push_back(7'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t1_spin", Affiche, i + 1);
    end
    chk("t1_occupe_hi", Occupe, 1);
    Lancer = 1'b0;
    @(negedge CLK); chk("t1_release", Affiche, 3);
    @(negedge CLK); chk("t1_decel1", Affiche, 4);
    @(negedge CLK); chk("t1_wait", Affiche, 4);
    @(negedge CLK); chk("t1_decel2", Affiche, 5);
    chk("t1_occupe_lo", Occupe, 0);
    @(negedge CLK); chk("t1_valide_off", Valide, 0);
    chk("t1_valeur_held", Valeur, 5);

    // 0..9, hold 12: counter 1 at release (wraps 9->0), settles to 3.
    roll("t2_wrap", 7'd0, 7'd9, 12, 0, 9, 7'd3, -1);

    // Degenerate range 5/2: everything pinned at 5.
    roll("t3_degen", 7'd5, 7'd2, 7, 5, 5, 7'd5, -1);

    // Re-press during deceleration: 1,2 | release(2) step 3 | re-press 3,4,5 | settle 6,1.
    @(negedge CLK);
    Min = 7'd1;
    Max = 7'd6;
    Lancer = 1'b1;
    exp_q.push_back(7'd1);
    @(negedge CLK); chk("t4_load", Affiche, 1);
    @(negedge CLK); chk("t4_step", Affiche, 2);
    Lancer = 1'b0;
    @(negedge CLK); chk("t4_release", Affiche, 2);
    @(negedge CLK); chk("t4_decel", Affiche, 3);
    Lancer = 1'b1;
    @(negedge CLK); chk("t4_resume", Affiche, 3);
    chk("t4_occupe", Occupe, 1);
    @(negedge CLK); chk("t4_spin4", Affiche, 4);
    @(negedge CLK); chk("t4_spin5", Affiche, 5);
    Lancer = 1'b0;
    wait_idle("t4_settle", 1, 6, 50);

    // Min/Max moved to 0/99 mid-spin: hold 11 gives 5 at release, settles 6 then 1.
    roll("t5_minmax_chg", 7'd1, 7'd6, 11, 1, 6, 7'd1, 3);

    // Reset mid-deceleration: outputs clear immediately, no Valide.
    @(negedge CLK);
    Min = 7'd1;
    Max = 7'd6;
    Lancer = 1'b1;
    repeat (3) @(negedge CLK);
    Lancer = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("t6_busy_before_rst", Occupe, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("t6_rst_affiche", Affiche, 0);
    chk("t6_rst_valeur", Valeur, 0);
    chk("t6_rst_valide", Valide, 0);
    chk("t6_rst_occupe", Occupe, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    chk("t6_idle_after_rst", Occupe, 0);

    // Fresh roll after reset starts from ATTENTE.
    roll("t7_after_rst", 7'd0, 7'd9, 12, 0, 9, 7'd3, -1);

    repeat (4) @(negedge CLK);
    chk("pending_results", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
